// File: rtl/and_unit_arbiter_if.sv
// Bundle between the requester blocks, the shared AND unit and and_unit_arbiter.
// slave is the arbiter side, master is the requester/unit side.
interface and_unit_arbiter_if #(
  parameter int N    = 4,
  parameter int A_W  = 2,
  parameter int B_W  = 3,
  parameter int C_W  = 4,
  parameter int ID_W = 2
);
  logic [N-1:0]     pi_req;
  logic [N*A_W-1:0] pi_a_bus;
  logic [N*B_W-1:0] pi_b_bus;
  logic [N-1:0]     po_gnt;
  logic [A_W-1:0]   po_unit_a;
  logic [B_W-1:0]   po_unit_b;
  logic [C_W-1:0]   pi_unit_c;
  logic             po_rsp_valid;
  logic             pi_rsp_ready;
  logic [C_W-1:0]   po_rsp_data;
  logic [ID_W-1:0]  po_rsp_id;
  logic             po_busy;

  modport slave (
    input  pi_req, pi_a_bus, pi_b_bus, pi_unit_c, pi_rsp_ready,
    output po_gnt, po_unit_a, po_unit_b, po_rsp_valid, po_rsp_data, po_rsp_id, po_busy
  );

  modport master (
    output pi_req, pi_a_bus, pi_b_bus, pi_unit_c, pi_rsp_ready,
    input  po_gnt, po_unit_a, po_unit_b, po_rsp_valid, po_rsp_data, po_rsp_id, po_busy
  );
endinterface

// File: rtl/and_unit_arbiter.sv
// Shares one registered AND unit among N requesters with one transaction in flight.
// Define AND_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module and_unit_arbiter #(
  parameter int N        = 4,
  parameter int A_W      = 2,
  parameter int B_W      = 3,
  parameter int C_W      = 4,
  parameter int UNIT_LAT = 1,
  parameter int ID_W     = 2
) (
  input logic               clk,
  input logic               rst,
  and_unit_arbiter_if.slave arb_if
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [A_W-1:0]   unit_a_q, unit_a_d;
  logic [B_W-1:0]   unit_b_q, unit_b_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [C_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]  win;
  logic             found;

`ifdef AND_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cand;
  int              sum;

  // Search upward from the pointer, wrapping N-1 -> 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    sum   = 0;
    for (int off = 0; off < N; off++) begin
      sum = int'(ptr_q) + off;
      if (sum >= N) sum = sum - N;
      cand = ID_W'(sum);
      if (!found && arb_if.pi_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && found) ptr_d = (int'(win) == N - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (arb_if.pi_req[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    unit_a_d = unit_a_q;
    unit_b_d = unit_b_q;
    id_d     = id_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          unit_a_d   = arb_if.pi_a_bus[win*A_W +: A_W];
          unit_b_d   = arb_if.pi_b_bus[win*B_W +: B_W];
          id_d       = win;
          gnt_d[win] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(UNIT_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // The unit result is valid on the edge where the count has reached zero.
        if (cnt_q == '0) begin
          data_d  = arb_if.pi_unit_c;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (arb_if.pi_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      unit_a_q <= '0;
      unit_b_q <= '0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      unit_a_q <= unit_a_d;
      unit_b_q <= unit_b_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign arb_if.po_gnt       = gnt_q;
  assign arb_if.po_unit_a    = unit_a_q;
  assign arb_if.po_unit_b    = unit_b_q;
  assign arb_if.po_rsp_valid = (state_q == RESP);
  assign arb_if.po_rsp_data  = data_q;
  assign arb_if.po_rsp_id    = id_q;
  assign arb_if.po_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Bench for and_unit_arbiter: one instance at UNIT_LAT=1 and one at UNIT_LAT=3,
// each with its own behavioural AND unit, checked against a transaction-level model.
module tb_and_unit_arbiter;
  localparam int N    = 4;
  localparam int A_W  = 2;
  localparam int B_W  = 3;
  localparam int C_W  = 4;
  localparam int ID_W = 2;
`ifdef AND_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   mptr  = 0;

  always #5 clk = ~clk;

  and_unit_arbiter_if #(.N(N), .A_W(A_W), .B_W(B_W), .C_W(C_W), .ID_W(ID_W)) if1 ();
  and_unit_arbiter_if #(.N(N), .A_W(A_W), .B_W(B_W), .C_W(C_W), .ID_W(ID_W)) if3 ();

  and_unit_arbiter #(.N(N), .A_W(A_W), .B_W(B_W), .C_W(C_W), .UNIT_LAT(1), .ID_W(ID_W))
    dut1 (.clk(clk), .rst(rst), .arb_if(if1));
  and_unit_arbiter #(.N(N), .A_W(A_W), .B_W(B_W), .C_W(C_W), .UNIT_LAT(3), .ID_W(ID_W))
    dut3 (.clk(clk), .rst(rst), .arb_if(if3));

  function automatic logic [C_W-1:0] and_ref(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    return C_W'(a) & C_W'(b);
  endfunction

  // Shared AND units: latency 1 and latency 3.
  logic [C_W-1:0] c3_p0, c3_p1, c3_p2;
  always @(posedge clk) if1.pi_unit_c <= C_W'(if1.po_unit_a) & C_W'(if1.po_unit_b);
  always @(posedge clk) begin
    c3_p0 <= C_W'(if3.po_unit_a) & C_W'(if3.po_unit_b);
    c3_p1 <= c3_p0;
    c3_p2 <= c3_p1;
  end
  assign if3.pi_unit_c = c3_p2;

  // Winner per arbitration rule: start at the pointer (round-robin) or at 0 (fixed).
  function automatic int pick(input logic [N-1:0] req);
    int start;
    start = RR_EN ? mptr : 0;
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N*A_W-1:0] rand_a();
    logic [31:0] r;
    r = $urandom;
    return r[N*A_W-1:0];
  endfunction

  function automatic logic [N*B_W-1:0] rand_b();
    logic [31:0] r;
    r = $urandom;
    return r[N*B_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the UNIT_LAT=1 instance; hold = cycles of ready=0 in RESP,
  // late_req = request vector driven from the cycle after the grant onward.
  task automatic txn1(input logic [N-1:0] req, input logic [N*A_W-1:0] abus,
                      input logic [N*B_W-1:0] bbus, input int hold, input logic [N-1:0] late_req);
    int             w;
    logic [A_W-1:0] ea;
    logic [B_W-1:0] eb;
    logic [C_W-1:0] ec;
    if1.pi_req       = req;
    if1.pi_a_bus     = abus;
    if1.pi_b_bus     = bbus;
    if1.pi_rsp_ready = (hold == 0);
    w    = pick(req);
    ea   = abus[w*A_W +: A_W];
    eb   = bbus[w*B_W +: B_W];
    ec   = and_ref(ea, eb);
    mptr = (w + 1) % N;
    step();
    chk("gnt", if1.po_gnt, 32'(1) << w);
    chk("unit_a", if1.po_unit_a, ea);
    chk("unit_b", if1.po_unit_b, eb);
    chk("busy", if1.po_busy, 1);
    if1.pi_req   = late_req;
    if1.pi_a_bus = rand_a();
    if1.pi_b_bus = rand_b();
    step();
    chk("gnt_clear", if1.po_gnt, 0);
    chk("valid_early", if1.po_rsp_valid, 0);
    chk("unit_a_held", if1.po_unit_a, ea);
    step();
    chk("valid", if1.po_rsp_valid, 1);
    chk("data", if1.po_rsp_data, ec);
    chk("id", if1.po_rsp_id, w);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bp_valid", if1.po_rsp_valid, 1);
      chk("bp_data", if1.po_rsp_data, ec);
      chk("bp_id", if1.po_rsp_id, w);
      chk("bp_gnt", if1.po_gnt, 0);
    end
    if1.pi_rsp_ready = 1'b1;
    step();
    chk("valid_drop", if1.po_rsp_valid, 0);
    chk("idle_busy", if1.po_busy, 0);
    chk("idle_gnt", if1.po_gnt, 0);
  endtask

  initial begin
    logic [N*A_W-1:0] a3;
    logic [N*B_W-1:0] b3;
    logic [C_W-1:0]   e3;
    int               w;
    if1.pi_req = '0; if1.pi_a_bus = '0; if1.pi_b_bus = '0; if1.pi_rsp_ready = 1'b0;
    if3.pi_req = '0; if3.pi_a_bus = '0; if3.pi_b_bus = '0; if3.pi_rsp_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_gnt", if1.po_gnt, 0);
    chk("rst_valid", if1.po_rsp_valid, 0);
    chk("rst_busy", if1.po_busy, 0);
    chk("rst_unit_a", if1.po_unit_a, 0);
    chk("rst_unit_b", if1.po_unit_b, 0);
    chk("rst_id", if1.po_rsp_id, 0);
    chk("rst_data", if1.po_rsp_data, 0);
    mptr = 0;

    // Single request: a=11, b=101 at requester 0 -> data 0001, id 0
    txn1(4'b0001, 8'h03, 12'h005, 0, 4'b0000);

    // Pointer back to 0, then all requesters held high
    rst = 1'b1; step(); rst = 1'b0; mptr = 0;
    for (int t = 0; t < 5; t++) txn1(4'b1111, rand_a(), rand_b(), 0, (t == 4) ? 4'b0000 : 4'b1111);

    // Back-pressure with a new request arriving during RESP
    txn1(4'b0001, rand_a(), rand_b(), 5, 4'b0100);
    txn1(4'b0100, rand_a(), rand_b(), 0, 4'b0000);

    // Random traffic
    for (int t = 0; t < 20; t++)
      txn1(4'($urandom_range(1, 15)), rand_a(), rand_b(), int'($urandom_range(0, 2)), 4'b0000);

    // Reset while in WAIT aborts the transaction
    if1.pi_req = 4'b1111; if1.pi_a_bus = rand_a(); if1.pi_b_bus = rand_b();
    w = pick(4'b1111);
    step();
    chk("abort_gnt", if1.po_gnt, 32'(1) << w);
    if1.pi_req = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mptr = 0;
    chk("abort_gnt0", if1.po_gnt, 0);
    chk("abort_valid", if1.po_rsp_valid, 0);
    chk("abort_busy", if1.po_busy, 0);
    chk("abort_unit_a", if1.po_unit_a, 0);
    chk("abort_unit_b", if1.po_unit_b, 0);
    chk("abort_id", if1.po_rsp_id, 0);
    chk("abort_data", if1.po_rsp_data, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_rsp", if1.po_rsp_valid, 0);
    end
    txn1(4'b1111, rand_a(), rand_b(), 0, 4'b0000);

    // UNIT_LAT=3 instance: requester 1, valid exactly 5 cycles after the request edge
    a3 = rand_a(); b3 = rand_b();
    e3 = and_ref(a3[1*A_W +: A_W], b3[1*B_W +: B_W]);
    if3.pi_req = 4'b0010; if3.pi_a_bus = a3; if3.pi_b_bus = b3; if3.pi_rsp_ready = 1'b0;
    step();
    chk("lat3_gnt", if3.po_gnt, 4'b0010);
    if3.pi_req = '0;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("lat3_valid_early", if3.po_rsp_valid, 0);
      if (k == 4) chk("lat3_unit_c", if3.pi_unit_c, e3);
    end
    step();
    chk("lat3_valid", if3.po_rsp_valid, 1);
    chk("lat3_data", if3.po_rsp_data, e3);
    chk("lat3_id", if3.po_rsp_id, 1);
    if3.pi_rsp_ready = 1'b1;
    step();
    chk("lat3_valid_drop", if3.po_rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
